// File: rtl/bsg_frame_loopback_multi.sv
// Frame-aware ring loopback node: rewrites each accepted packet by mode, queues it in a
// small FIFO and returns it to the ring, with saturating rx/tx/drop counters for bring-up.
module bsg_frame_loopback_multi #(
    parameter int ring_width_p = 80,
    parameter int id_width_p   = 4,
    parameter int els_p        = 4,
    parameter int cnt_width_p  = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    v_i,
    input  logic [ring_width_p-1:0] data_i,
    output logic                    ready_o,
    output logic                    v_o,
    output logic [ring_width_p-1:0] data_o,
    input  logic                    yumi_i,
    input  logic [1:0]              mode_i,
    input  logic [id_width_p-1:0]   node_id_i,
    input  logic                    flush_i,
    output logic [cnt_width_p-1:0]  rx_cnt_o,
    output logic [cnt_width_p-1:0]  tx_cnt_o,
    output logic [cnt_width_p-1:0]  drop_cnt_o
);

    localparam int ptr_w_lp = $clog2(els_p);
    localparam int occ_w_lp = ptr_w_lp + 1;
    localparam int pay_w_lp = ring_width_p - 2 * id_width_p;

    localparam logic [ptr_w_lp-1:0]    ptr_one_lp = 1;
    localparam logic [occ_w_lp-1:0]    occ_one_lp = 1;
    localparam logic [occ_w_lp-1:0]    occ_full_lp = occ_w_lp'(els_p);
    localparam logic [cnt_width_p-1:0] cnt_one_lp = 1;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_SWAP  = 2'd1,
        MODE_STAMP = 2'd2,
        MODE_DROP  = 2'd3
    } mode_e;

    logic [ring_width_p-1:0] mem_q [els_p];
    logic [ptr_w_lp-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [occ_w_lp-1:0]     occ_q, occ_d;
    logic                    live_q;
    logic [cnt_width_p-1:0]  rx_q, tx_q, drop_q;

    logic                    full, accept, store, deq;
    logic [ring_width_p-1:0] wdata;
    logic [id_width_p-1:0]   dst_id, src_id;
    logic [pay_w_lp-1:0]     payload;
    mode_e                   mode;

    assign mode    = mode_e'(mode_i);
    assign dst_id  = data_i[ring_width_p-1 -: id_width_p];
    assign src_id  = data_i[ring_width_p-id_width_p-1 -: id_width_p];
    assign payload = data_i[pay_w_lp-1:0];

    // live_q holds ready_o low until the first clock edge after reset release.
    assign full    = (occ_q == occ_full_lp);
    assign ready_o = live_q & ~full & ~flush_i;
    assign accept  = v_i & ready_o;
    assign store   = accept & (mode != MODE_DROP);
    assign deq     = yumi_i & v_o & ~flush_i;

    assign v_o    = (occ_q != '0);
    assign data_o = mem_q[rptr_q];

    always_comb begin
        wdata = data_i;
        case (mode)
            MODE_SWAP:  wdata = {src_id, dst_id, payload};
            MODE_STAMP: wdata = {src_id, node_id_i, payload};
            default:    wdata = data_i;
        endcase
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            occ_d  = '0;
        end else begin
            if (store) wptr_d = wptr_q + ptr_one_lp;
            if (deq)   rptr_d = rptr_q + ptr_one_lp;
            if (store && !deq)      occ_d = occ_q + occ_one_lp;
            else if (!store && deq) occ_d = occ_q - occ_one_lp;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
            live_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
            live_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (store) mem_q[wptr_q] <= wdata;
    end

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rx_q   <= '0;
            tx_q   <= '0;
            drop_q <= '0;
        end else begin
            if (accept && (rx_q != '1)) rx_q <= rx_q + cnt_one_lp;
            if (yumi_i && (tx_q != '1)) tx_q <= tx_q + cnt_one_lp;
            if (accept && (mode == MODE_DROP) && (drop_q != '1)) drop_q <= drop_q + cnt_one_lp;
        end
    end

    assign rx_cnt_o   = rx_q;
    assign tx_cnt_o   = tx_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_bsg_frame_loopback_multi.sv
// Bench for bsg_frame_loopback_multi: directed scenarios plus random traffic against a
// queue-based reference model; narrow counters make saturation reachable.
module tb_bsg_frame_loopback_multi;

    localparam int RW = 80;
    localparam int IW = 4;
    localparam int EL = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          v_i = 1'b0;
    logic [RW-1:0] data_i = '0;
    logic          ready_o;
    logic          v_o;
    logic [RW-1:0] data_o;
    logic          yumi_i = 1'b0;
    logic [1:0]    mode_i = 2'd0;
    logic [IW-1:0] node_id = 4'd9;
    logic          flush_i = 1'b0;
    logic [CW-1:0] rx_cnt, tx_cnt, drop_cnt;

    bsg_frame_loopback_multi #(
        .ring_width_p(RW),
        .id_width_p  (IW),
        .els_p       (EL),
        .cnt_width_p (CW)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .v_i       (v_i),
        .data_i    (data_i),
        .ready_o   (ready_o),
        .v_o       (v_o),
        .data_o    (data_o),
        .yumi_i    (yumi_i),
        .mode_i    (mode_i),
        .node_id_i (node_id),
        .flush_i   (flush_i),
        .rx_cnt_o  (rx_cnt),
        .tx_cnt_o  (tx_cnt),
        .drop_cnt_o(drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [RW-1:0] mq[$];
    int  m_rx = 0, m_tx = 0, m_drop = 0;
    bit  m_live = 0;

    task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (reset_n && yumi_i && !v_o) begin
            bad++;
            $display("FAIL yumi_while_empty got=1 exp=0");
        end
    end

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    function automatic logic [RW-1:0] rewrite(input logic [RW-1:0] p, input int mode);
        logic [IW-1:0]      dst, src;
        logic [RW-2*IW-1:0] pay;
        dst = p[RW-1 -: IW];
        src = p[RW-IW-1 -: IW];
        pay = p[RW-2*IW-1:0];
        if (mode == 1) return {src, dst, pay};
        if (mode == 2) return {src, node_id, pay};
        return p;
    endfunction

    function automatic logic [RW-1:0] rnd_pkt();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[RW-1:0];
    endfunction

    task automatic chk_counters(input string tag);
        chk({tag, "_rx"},   RW'(rx_cnt),   RW'(m_rx));
        chk({tag, "_tx"},   RW'(tx_cnt),   RW'(m_tx));
        chk({tag, "_drop"}, RW'(drop_cnt), RW'(m_drop));
    endtask

    task automatic cycle(input logic v, input logic [RW-1:0] d, input logic [1:0] m,
                         input logic y, input logic f);
        bit   exp_rdy, acc;
        logic yy;
        @(negedge clk);
        yy = y && (mq.size() != 0);
        v_i = v; data_i = d; mode_i = m; yumi_i = yy; flush_i = f;
        #1;
        exp_rdy = m_live && (mq.size() < EL) && !f;
        chk("ready", RW'(ready_o), RW'(exp_rdy));
        chk("v_o", RW'(v_o), RW'(mq.size() != 0));
        if (mq.size() != 0) chk("data", data_o, mq[0]);
        @(posedge clk);
        acc = v && exp_rdy;
        if (acc) m_rx = sat(m_rx + 1);
        if (yy) m_tx = sat(m_tx + 1);
        if (acc && m == 2'd3) m_drop = sat(m_drop + 1);
        if (f) mq.delete();
        else begin
            if (yy) void'(mq.pop_front());
            if (acc && m != 2'd3) mq.push_back(rewrite(d, int'(m)));
        end
        m_live = 1;
        #1;
        chk_counters("cnt");
    endtask

    task automatic hit_reset();
        @(negedge clk);
        v_i = 0; yumi_i = 0; flush_i = 0;
        #2 reset_n = 0;
        #1;
        chk("rst_v_o", RW'(v_o), RW'(0));
        chk("rst_ready", RW'(ready_o), RW'(0));
        mq.delete();
        m_rx = 0; m_tx = 0; m_drop = 0; m_live = 0;
        chk_counters("rst");
        @(negedge clk);
        reset_n = 1;
        #1 chk("rel_ready_pre", RW'(ready_o), RW'(0));
        @(posedge clk);
        #1 chk("rel_ready_post", RW'(ready_o), RW'(1));
        m_live = 1;
    endtask

    initial begin
        #3;
        chk("init_v_o", RW'(v_o), RW'(0));
        chk("init_ready", RW'(ready_o), RW'(0));
        chk_counters("init");
        hit_reset();

        // SWAP
        cycle(1, {4'd3, 4'd5, 72'hABC}, 2'd1, 0, 0);
        chk("swap_v", RW'(v_o), RW'(1));
        chk("swap_data", data_o, {4'd5, 4'd3, 72'hABC});
        chk("swap_rx", RW'(rx_cnt), RW'(1));
        cycle(0, '0, 2'd0, 1, 0);
        chk("swap_tx", RW'(tx_cnt), RW'(1));
        chk("swap_empty", RW'(v_o), RW'(0));

        // STAMP then switch to PASS with packets queued
        cycle(1, {4'd2, 4'd7, 72'h111}, 2'd2, 0, 0);
        cycle(1, {4'd1, 4'd4, 72'h222}, 2'd2, 0, 0);
        cycle(1, {4'd6, 4'd8, 72'h333}, 2'd0, 0, 0);
        chk("stamp_head", data_o, {4'd7, 4'd9, 72'h111});
        cycle(0, '0, 2'd0, 1, 0);
        chk("stamp_2nd", data_o, {4'd4, 4'd9, 72'h222});
        cycle(0, '0, 2'd0, 1, 0);
        chk("pass_3rd", data_o, {4'd6, 4'd8, 72'h333});
        cycle(0, '0, 2'd0, 1, 0);

        // Fill, no bypass, drain order
        hit_reset();
        for (int i = 0; i < EL; i++) cycle(1, rnd_pkt(), 2'd0, 0, 0);
        chk("full_ready", RW'(ready_o), RW'(0));
        cycle(1, rnd_pkt(), 2'd0, 0, 0);
        chk("full_rx", RW'(rx_cnt), RW'(EL));
        cycle(1, rnd_pkt(), 2'd0, 1, 0);
        cycle(1, rnd_pkt(), 2'd0, 0, 0);
        for (int i = 0; i < EL; i++) cycle(0, '0, 2'd0, 1, 0);

        // DROP
        hit_reset();
        for (int i = 0; i < 10; i++) cycle(1, rnd_pkt(), 2'd3, 0, 0);
        chk("drop_cnt", RW'(drop_cnt), RW'(10));
        chk("drop_rx", RW'(rx_cnt), RW'(10));
        chk("drop_tx", RW'(tx_cnt), RW'(0));
        chk("drop_v_o", RW'(v_o), RW'(0));

        // Flush with 3 queued and v_i held
        hit_reset();
        for (int i = 0; i < 3; i++) cycle(1, rnd_pkt(), 2'd1, 0, 0);
        cycle(1, rnd_pkt(), 2'd0, 0, 1);
        chk("flush_v_o", RW'(v_o), RW'(0));
        chk("flush_rx", RW'(rx_cnt), RW'(3));
        cycle(1, rnd_pkt(), 2'd0, 0, 0);

        // Random traffic
        hit_reset();
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), rnd_pkt(), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0));

        // Saturation and mid-stream reset
        hit_reset();
        for (int i = 0; i < 20; i++) cycle(1, rnd_pkt(), 2'd0, 1, 0);
        chk("sat_rx", RW'(rx_cnt), RW'(CMAX));
        chk("sat_tx", RW'(tx_cnt), RW'(CMAX));
        cycle(1, rnd_pkt(), 2'd0, 0, 0);
        hit_reset();
        cycle(1, rnd_pkt(), 2'd2, 0, 0);
        cycle(0, '0, 2'd0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
